// File: rtl/seq_detector_sched.sv
// seq_detector_sched: arbitrates two word requesters onto one shared serial "0110" detector.
// Define SEQDET_RR_EN for round-robin tie breaking; otherwise requester 0 always wins a tie.
module seq_detector_sched #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [W-1:0]     req_data0,
    input  logic [W-1:0]     req_data1,
    output logic [1:0]       req_ready,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             res_id
);

    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [W-1:0]     shreg_q;
    logic [BW-1:0]    bitCnt_q;
    logic [CNT_W-1:0] count_q;
    logic             detRst_q;
    logic             resValid_q;
    logic             resId_q;
    logic [1:0]       grant_d;
`ifdef SEQDET_RR_EN
    logic             lastId_q;
`endif

    // Grant is only offered in IDLE and never while reset is being applied.
    always_comb begin
        grant_d = 2'b00;
        if (rst && state_q == IDLE) begin
            case (req_valid)
                2'b01:   grant_d = 2'b01;
                2'b10:   grant_d = 2'b10;
`ifdef SEQDET_RR_EN
                2'b11:   grant_d = lastId_q ? 2'b01 : 2'b10;
`else
                2'b11:   grant_d = 2'b01;
`endif
                default: grant_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bitCnt_q   <= '0;
            count_q    <= '0;
            detRst_q   <= 1'b1;
            resValid_q <= 1'b0;
            resId_q    <= 1'b0;
`ifdef SEQDET_RR_EN
            lastId_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    detRst_q <= 1'b0;
                    if (grant_d != 2'b00) begin
                        shreg_q  <= grant_d[1] ? req_data1 : req_data0;
                        resId_q  <= grant_d[1];
                        count_q  <= '0;
                        detRst_q <= 1'b1;
                        state_q  <= CLR;
`ifdef SEQDET_RR_EN
                        lastId_q <= grant_d[1];
`endif
                    end
                end
                CLR: begin
                    detRst_q <= 1'b0;
                    bitCnt_q <= BW'(W - 1);
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    // det_z is the Mealy response to the bit currently on det_x.
                    if (det_z && count_q != {CNT_W{1'b1}})
                        count_q <= count_q + 1'b1;
                    shreg_q <= {shreg_q[W-2:0], 1'b0};
                    if (bitCnt_q == '0) begin
                        state_q    <= DONE;
                        resValid_q <= 1'b1;
                    end else begin
                        bitCnt_q <= bitCnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = grant_d;
    assign det_x     = (state_q == SHIFT) & shreg_q[W-1];
    assign det_rst   = detRst_q;
    assign res_valid = resValid_q;
    assign res_count = count_q;
    assign res_hit   = |count_q;
    assign res_id    = resId_q;

endmodule

// File: tb/tb_seq_detector_sched.sv
// Scoreboard bench for seq_detector_sched with a behavioural "0110" detector stub.
// Expected results come from counting pattern occurrences in each accepted word.
module tb_seq_detector_sched;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [W-1:0]     req_data0 = '0;
    logic [W-1:0]     req_data1 = '0;
    logic [1:0]       req_ready;
    logic             det_x;
    logic             det_rst;
    logic             det_z;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [CNT_W-1:0] res_count;
    logic             res_hit;
    logic             res_id;

    seq_detector_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .det_x(det_x), .det_rst(det_rst),
        .det_z(det_z), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_hit(res_hit), .res_id(res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             hit;
        logic             id;
        int               acc;
    } exp_t;

    exp_t sb[$];
    logic grantLog[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   grantCount = 0;
    logic rstSeen = 1'b0;
    logic lastGrant = 1'b1;
    logic prevValid = 1'b0;
    logic [CNT_W-1:0] heldCnt;
    logic heldHit, heldId;

    // Detector stub: remembers the last three bits since its clear.
    logic [2:0] win = 3'b000;
    int         len = 0;
    assign det_z = (len >= 3) && (win == 3'b011) && !det_x;
    always @(posedge clk) begin
        if (det_rst) begin
            win <= 3'b000;
            len <= 0;
        end else begin
            win <= {win[1:0], det_x};
            len <= (len < 3) ? len + 1 : len;
        end
    end

    always @(posedge clk) begin
        cyc++;
        rstSeen = rst;
    end

    function automatic logic [CNT_W-1:0] refCount(input logic [W-1:0] word);
        int n = 0;
        for (int i = 0; i <= W - 4; i++)
            if (word[W-1-i -: 4] == 4'b0110) n++;
        if (n > MAXC) n = MAXC;
        return CNT_W'(n);
    endfunction

    function automatic logic [1:0] refGrant(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
`ifdef SEQDET_RR_EN
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
`else
        if (v == 2'b11) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: reset checks, grant model and result scoreboard, all sampled on negedge.
    always @(negedge clk) begin
        if (!rstSeen) begin
            checkOutput("rst_req_ready", int'(req_ready), 0);
            checkOutput("rst_res_valid", int'(res_valid), 0);
            checkOutput("rst_det_x", int'(det_x), 0);
            checkOutput("rst_det_rst", int'(det_rst), 1);
            checkOutput("rst_res_count", int'(res_count), 0);
            checkOutput("rst_res_hit", int'(res_hit), 0);
            checkOutput("rst_res_id", int'(res_id), 0);
            sb.delete();
            lastGrant = 1'b1;
            prevValid = 1'b0;
        end else begin
            if (req_ready != 2'b00) begin
                logic [1:0] mg;
                exp_t e;
                mg = refGrant(req_valid, lastGrant);
                checkOutput("grant", int'(req_ready), int'(mg));
                e.id  = mg[1];
                e.cnt = refCount(mg[1] ? req_data1 : req_data0);
                e.hit = (e.cnt != 0);
                e.acc = cyc;
                sb.push_back(e);
                grantLog.push_back(mg[1]);
                lastGrant = mg[1];
                grantCount++;
            end
            if (res_valid) begin
                checkOutput("ready_while_valid", int'(req_ready), 0);
                if (!prevValid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_result", 1, 0);
                    end else begin
                        checkOutput("res_count", int'(res_count), int'(sb[0].cnt));
                        checkOutput("res_hit", int'(res_hit), int'(sb[0].hit));
                        checkOutput("res_id", int'(res_id), int'(sb[0].id));
                        checkOutput("latency", cyc - sb[0].acc, W + 2);
                    end
                    heldCnt = res_count;
                    heldHit = res_hit;
                    heldId  = res_id;
                end else begin
                    checkOutput("hold_count", int'(res_count), int'(heldCnt));
                    checkOutput("hold_hit", int'(res_hit), int'(heldHit));
                    checkOutput("hold_id", int'(res_id), int'(heldId));
                end
                if (res_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    prevValid = 1'b0;
                end else begin
                    prevValid = 1'b1;
                end
            end else begin
                prevValid = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int who, input logic [W-1:0] word);
        bit got = 0;
        @(posedge clk); #1;
        if (who == 0) req_data0 = word; else req_data1 = word;
        req_valid[who] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready[who]) got = 1;
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[who] = 1'b0;
    endtask

    task automatic waitDrain();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !res_valid && req_valid == 2'b00) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        applyStimulus(0, 8'b0110_0000);
        applyStimulus(1, 8'b0110_1100);
        applyStimulus(1, 8'hFF);
        applyStimulus(0, 8'b0000_0011);
        applyStimulus(0, 8'b0000_0000);
        waitDrain();

        // Tie: both requesters held high for three grants.
        begin
            int base;
            bit got = 0;
            logic expIds [3];
`ifdef SEQDET_RR_EN
            expIds = '{1'b0, 1'b1, 1'b0};
`else
            expIds = '{1'b0, 1'b0, 1'b0};
`endif
            base = grantCount;
            grantLog.delete();
            @(posedge clk); #1;
            req_data0 = 8'b0110_0000;
            req_data1 = 8'b0110_1100;
            req_valid = 2'b11;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (grantCount >= base + 3) got = 1;
            end
            if (!got) checkOutput("tie_timeout", 0, 1);
            @(posedge clk); #1;
            req_valid = 2'b00;
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("tie_grant%0d", i),
                            (grantLog.size() > i) ? int'(grantLog[i]) : -1, int'(expIds[i]));
            waitDrain();
        end

        // Backpressure with a competing request pending during DONE.
        begin
            bit got = 0;
            res_ready = 1'b0;
            applyStimulus(0, 8'b0110_0000);
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (res_valid) got = 1;
            end
            if (!got) checkOutput("bp_valid_timeout", 0, 1);
            @(posedge clk); #1;
            req_data1 = 8'b0110_1100;
            req_valid[1] = 1'b1;
            repeat (5) @(posedge clk);
            #1 res_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            checkOutput("idle_after_ready", int'(req_ready), 2);
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            waitDrain();
        end

        // Reset while the detector is being fed bit 4.
        applyStimulus(0, 8'b0110_0110);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("no_result_after_reset", int'(res_valid), 0);
        applyStimulus(0, 8'b1011_0110);
        waitDrain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] g;
            @(negedge clk);
            g = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    if (i == 0) req_data0 = W'($urandom); else req_data1 = W'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom % 4) != 0;
        end
        begin
            logic [1:0] g;
            @(negedge clk);
            g = req_ready;
            @(posedge clk); #1;
            req_valid = 2'b00;
            if (g == 2'b00) ;
        end
        res_ready = 1'b1;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
